wb_select_hs: RTL and testbench



---
 rtl/wb_select_hs_if.sv | 27 ++
 rtl/wb_select_hs.sv | 120 ++++++++++++
 tb/tb_wb_select_hs.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_select_hs_if.sv
// Write-back selector bus: source data/valid vectors, request/select, and the registered result handshake.
// The master drives the sources, request and ack; the slave (the selector) returns busy and the write-back result.
interface wb_select_hs_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int SELW  = 3
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_valid;
  logic [SELW-1:0]       sel;
  logic                  req;
  logic                  busy;
  logic [WIDTH-1:0]      wb_data;
  logic                  wb_valid;
  logic                  wb_err;
  logic                  wb_ack;

  modport master (
    output src_data, src_valid, sel, req, wb_ack,
    input  busy, wb_data, wb_valid, wb_err
  );

  modport slave (
    input  src_data, src_valid, sel, req, wb_ack,
    output busy, wb_data, wb_valid, wb_err
  );
endinterface

// File: rtl/wb_select_hs.sv
// Registered write-back source selector; waits for a multi-cycle source, with an optional timeout.
// Latency is one cycle after the selected source is valid; the result is held until wb_ack.
module wb_select_hs #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 5,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  wb_select_hs_if.slave bus
);

  localparam int NPAD = 2 ** SELW;
  localparam int CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SELW-1:0] LAST     = SELW'(NSRC - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam bit              TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t           state, state_n;
  logic [SELW-1:0]  sel_q, sel_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;

  logic [SELW-1:0]  eff;
  logic             accept;
  logic [NPAD-1:0]  vld_pad;
  logic [WIDTH-1:0] src_arr [NPAD];

  // Pad sources to the full select range so any select value indexes safely.
  for (genvar g = 0; g < NPAD; g++) begin : g_src
    if (g < NSRC) begin : g_real
      assign src_arr[g] = bus.src_data[g*WIDTH +: WIDTH];
      assign vld_pad[g] = bus.src_valid[g];
    end else begin : g_pad
      assign src_arr[g] = '0;
      assign vld_pad[g] = 1'b0;
    end
  end

  assign eff    = (bus.sel > LAST) ? LAST : bus.sel;
  assign accept = bus.req && ((state == IDLE) || (state == OUT && bus.wb_ack));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      cnt     <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    cnt_n   = cnt;
    data_n  = data_q;
    valid_n = valid_q;
    err_n   = err_q;
    if (accept) begin
      // Back-to-back acceptance in OUT behaves exactly like a request from IDLE.
      sel_n = eff;
      cnt_n = '0;
      err_n = 1'b0;
      if (vld_pad[eff]) begin
        data_n  = src_arr[eff];
        valid_n = 1'b1;
        state_n = OUT;
      end else begin
        valid_n = 1'b0;
        state_n = WAIT;
      end
    end else begin
      case (state)
        WAIT: begin
          if (vld_pad[sel_q]) begin
            data_n  = src_arr[sel_q];
            err_n   = 1'b0;
            valid_n = 1'b1;
            state_n = OUT;
          end else if (TMO_EN && cnt == CNT_LAST) begin
            data_n  = '0;
            err_n   = 1'b1;
            valid_n = 1'b1;
            state_n = OUT;
          end else if (cnt != {CW{1'b1}}) begin
            cnt_n = cnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.wb_ack) begin
            valid_n = 1'b0;
            err_n   = 1'b0;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.wb_data  = data_q;
  assign bus.wb_valid = valid_q;
  assign bus.wb_err   = err_q;

endmodule

// File: tb/tb_wb_select_hs.sv
// Directed and randomized bench for wb_select_hs, checked against a transaction-level model of the selector.
module tb_wb_select_hs;
  localparam int W   = 32;
  localparam int N   = 5;
  localparam int SW  = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  wb_select_hs_if #(.WIDTH(W), .NSRC(N), .SELW(SW)) bus ();

  wb_select_hs #(.WIDTH(W), .NSRC(N), .SELW(SW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: request accepted in cycle 0; source first valid in cycle 'delay'.
  // Valid in cycle j <= TMO gives data in cycle j+1, otherwise an error result in cycle TMO+1.
  task automatic run_txn(input logic [SW-1:0] s, input int delay, input int hold,
                         input logic [W-1:0] d, input bit do_ack);
    int           eff;
    int           e;
    bit           timed_out;
    logic [W-1:0] exp_d;
    eff       = (int'(s) < N) ? int'(s) : N - 1;
    timed_out = (delay > TMO);
    e         = timed_out ? TMO + 1 : delay + 1;
    exp_d     = timed_out ? '0 : d;
    for (int i = 0; i < N; i++) bus.src_data[i*W +: W] = $urandom;
    bus.src_data[eff*W +: W] = d;
    bus.src_valid      = N'($urandom);
    bus.src_valid[eff] = (delay == 0);
    bus.sel    = s;
    bus.req    = 1'b1;
    bus.wb_ack = 1'b0;
    tick();
    bus.req = 1'b0;
    for (int c = 1; c <= e; c++) begin
      check("busy_pending", bus.busy, 1);
      check("valid_timing", bus.wb_valid, (c == e));
      if (c < e) begin
        bus.sel            = SW'($urandom);
        bus.src_valid      = N'($urandom);
        bus.src_valid[eff] = (c == delay);
        tick();
      end
    end
    check("wb_data", bus.wb_data, exp_d);
    check("wb_err", bus.wb_err, timed_out);
    bus.src_valid = N'($urandom);
    bus.src_data[eff*W +: W] = $urandom;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", bus.wb_valid, 1);
      check("hold_data", bus.wb_data, exp_d);
      check("hold_err", bus.wb_err, timed_out);
    end
    if (do_ack) begin
      bus.wb_ack = 1'b1;
      tick();
      bus.wb_ack = 1'b0;
      check("ack_valid", bus.wb_valid, 0);
      check("ack_err", bus.wb_err, 0);
      check("ack_busy", bus.busy, 0);
    end
  endtask

  initial begin
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.sel       = '0;
    bus.req       = 1'b0;
    bus.wb_ack    = 1'b0;
    #3;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.wb_valid, 0);
    check("rst_err", bus.wb_err, 0);
    check("rst_data", bus.wb_data, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Immediate capture, held 3 cycles.
    run_txn(3'd0, 0, 3, 32'h1234_5678, 1'b1);
    // Wait for a load, select wiggling during WAIT.
    run_txn(3'd1, 5, 1, 32'hDEAD_BEEF, 1'b1);
    // Out-of-range select falls back to the last source.
    run_txn(3'd7, 0, 0, 32'hBFC0_0380, 1'b1);
    // Timeout, then valid arriving on the final waiting cycle.
    run_txn(3'd3, 99, 1, 32'h5555_AAAA, 1'b1);
    run_txn(3'd3, TMO, 1, 32'h7777_0001, 1'b1);

    // Ack while idle is ignored.
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    check("idle_ack_busy", bus.busy, 0);
    check("idle_ack_valid", bus.wb_valid, 0);

    // Back-to-back: valid new source keeps wb_valid high.
    run_txn(3'd0, 0, 0, 32'hCAFE_0001, 1'b0);
    bus.src_data[2*W +: W] = 32'h0040_0008;
    bus.src_valid = 5'b00100;
    bus.sel       = 3'd2;
    bus.req       = 1'b1;
    bus.wb_ack    = 1'b1;
    tick();
    check("b2b_valid", bus.wb_valid, 1);
    check("b2b_data", bus.wb_data, 32'h0040_0008);
    check("b2b_err", bus.wb_err, 0);
    // Back-to-back with the new source not ready drops wb_valid and waits.
    bus.src_valid = 5'b00000;
    tick();
    bus.req    = 1'b0;
    bus.wb_ack = 1'b0;
    check("b2b_wait_valid", bus.wb_valid, 0);
    check("b2b_wait_busy", bus.busy, 1);
    bus.src_data[2*W +: W] = 32'h1111_2222;
    bus.src_valid = 5'b00100;
    bus.sel       = 3'd0;
    tick();
    bus.src_valid = '0;
    check("b2b_late_valid", bus.wb_valid, 1);
    check("b2b_late_data", bus.wb_data, 32'h1111_2222);
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    check("b2b_done_busy", bus.busy, 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 24; t++) begin
      run_txn(SW'($urandom_range(0, 7)), $urandom_range(0, 10), $urandom_range(0, 2),
              $urandom, 1'b1);
    end

    // Asynchronous reset in WAIT, mid-cycle.
    run_txn(3'd2, 0, 0, 32'hABCD_0123, 1'b0);
    bus.src_valid = '0;
    bus.sel       = 3'd3;
    bus.req       = 1'b1;
    bus.wb_ack    = 1'b1;
    tick();
    bus.req    = 1'b0;
    bus.wb_ack = 1'b0;
    tick();
    check("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_valid", bus.wb_valid, 0);
    check("arst_data", bus.wb_data, 0);
    check("arst_err", bus.wb_err, 0);
    tick();
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.src_valid = '1;
      tick();
      check("post_rst_valid", bus.wb_valid, 0);
      check("post_rst_busy", bus.busy, 0);
    end
    bus.src_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end
endmodule
